// File: rtl/az_sequencer_pkg.sv
// Shared constants and state encoding for the auto-zero measurement sequencer.
// State values are fixed so the monitor port can be decoded externally.
package az_sequencer_pkg;

  localparam int unsigned CLK_FREQ = 20_000_000;

  localparam logic SW_PC_SIGNAL = 1'b1;
  localparam logic SW_PC_BOOT   = 1'b0;

  // AZ mux codes: bit 3 enables the mux, bits 2:0 select input n-1.
  localparam logic [3:0] AZMUX_S1 = 4'((1 << 3) | 0);
  localparam logic [3:0] AZMUX_S2 = 4'((1 << 3) | 1);
  localparam logic [3:0] AZMUX_S3 = 4'((1 << 3) | 2);
  localparam logic [3:0] AZMUX_S4 = 4'((1 << 3) | 3);
  localparam logic [3:0] AZMUX_S5 = 4'((1 << 3) | 4);
  localparam logic [3:0] AZMUX_S6 = 4'((1 << 3) | 5);
  localparam logic [3:0] AZMUX_S7 = 4'((1 << 3) | 6);
  localparam logic [3:0] AZMUX_S8 = 4'((1 << 3) | 7);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PROTECT   = 3'd1,
    ST_SETTLE_HI = 3'd2,
    ST_MEAS_HI   = 3'd3,
    ST_REPROTECT = 3'd4,
    ST_MEAS_LO   = 3'd5,
    ST_CHECK     = 3'd6,
    ST_DONE      = 3'd7
  } state_e;

endpackage

// File: rtl/az_sequencer_settle_timer.sv
// Loadable saturating down-counter; a load of N keeps expired low for N-1
// cycles, so a phase gated on expired lasts max(N, 1) cycles.
module az_sequencer_settle_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_val == '0) ? '0 : load_val - W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/az_sequencer.sv
// Start/stop controlled, count-limited sequencer for the precharge switch and
// AZ mux, handshaking each hi/lo conversion with the ADC front end.
module az_sequencer #(
  parameter int   PC_W         = 24,
  parameter int   N_W          = 16,
  parameter logic SW_PC_SIGNAL = az_sequencer_pkg::SW_PC_SIGNAL,
  parameter logic SW_PC_BOOT   = az_sequencer_pkg::SW_PC_BOOT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stop,
  input  logic            mode_az,
  input  logic [3:0]      azmux_hi_val,
  input  logic [3:0]      azmux_lo_val,
  input  logic [PC_W-1:0] precharge_clks,
  input  logic [N_W-1:0]  sample_count,
  input  logic [31:0]     adc_timeout_clks,
  input  logic            adc_done,
  output logic            adc_start,
  output logic            adc_is_hi,
  output logic            sw_pc_ctl,
  output logic [3:0]      azmux,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [N_W-1:0]  sample_idx,
  output logic            led0,
  output logic [7:0]      monitor
);

  import az_sequencer_pkg::*;

  state_e          state_q, state_d;
  logic            mode_az_q, mode_az_d;
  logic [3:0]      hi_val_q, hi_val_d, lo_val_q, lo_val_d;
  logic [PC_W-1:0] pc_clks_q, pc_clks_d;
  logic [N_W-1:0]  count_q, count_d;
  logic [31:0]     to_clks_q, to_clks_d;
  logic            stop_lat_q, stop_lat_d;
  logic            error_q, error_d;
  logic [N_W-1:0]  idx_q, idx_d;
  logic            sw_pc_q, sw_pc_d;
  logic [3:0]      azmux_q, azmux_d;
  logic            adc_start_q, adc_start_d;
  logic            adc_is_hi_q, adc_is_hi_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            led0_q, led0_d;
  logic            adc_done_q;

  logic            start_acc, done_acc, timeout, last_cycle, entering;
  logic            pc_load, pc_expired, to_load, to_expired;
  logic [PC_W-1:0] pc_load_val;

  // adc_done is only accepted after the adc_start cycle of a conversion.
  assign start_acc  = (state_q == ST_IDLE) && start;
  assign done_acc   = adc_done && !adc_start_q;
  assign timeout    = (to_clks_q != '0) && to_expired && !done_acc;
  assign last_cycle = stop_lat_q ||
                      ((count_q != '0) && ((idx_q + N_W'(1)) == count_q));
  assign entering   = (state_d != state_q);

  // Settle load comes straight from the input on the run's first phase.
  assign pc_load     = entering &&
                       (state_d inside {ST_PROTECT, ST_SETTLE_HI, ST_REPROTECT});
  assign pc_load_val = (state_q == ST_IDLE) ? precharge_clks : pc_clks_q;
  assign to_load     = entering && (state_d inside {ST_MEAS_HI, ST_MEAS_LO});

  az_sequencer_settle_timer #(.W(PC_W)) u_pc_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .load_val (pc_load_val),
    .expired  (pc_expired)
  );

  az_sequencer_settle_timer #(.W(32)) u_to_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (to_load),
    .load_val (to_clks_q),
    .expired  (to_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start) state_d = ST_PROTECT;
      ST_PROTECT:   if (pc_expired) state_d = ST_SETTLE_HI;
      ST_SETTLE_HI: if (pc_expired) state_d = ST_MEAS_HI;
      ST_MEAS_HI: begin
        if (done_acc)     state_d = mode_az_q ? ST_REPROTECT : ST_CHECK;
        else if (timeout) state_d = ST_DONE;
      end
      ST_REPROTECT: if (pc_expired) state_d = ST_MEAS_LO;
      ST_MEAS_LO: begin
        if (done_acc)     state_d = ST_CHECK;
        else if (timeout) state_d = ST_DONE;
      end
      ST_CHECK: begin
        if (last_cycle)   state_d = ST_DONE;
        else if (mode_az_q) state_d = ST_SETTLE_HI;
        else              state_d = ST_MEAS_HI;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Run configuration, stop latch, error flag and completed-cycle count.
  always_comb begin
    mode_az_d  = mode_az_q;
    hi_val_d   = hi_val_q;
    lo_val_d   = lo_val_q;
    pc_clks_d  = pc_clks_q;
    count_d    = count_q;
    to_clks_d  = to_clks_q;
    stop_lat_d = stop_lat_q;
    error_d    = error_q;
    idx_d      = idx_q;
    if (start_acc) begin
      mode_az_d  = mode_az;
      hi_val_d   = azmux_hi_val;
      lo_val_d   = azmux_lo_val;
      pc_clks_d  = precharge_clks;
      count_d    = sample_count;
      to_clks_d  = adc_timeout_clks;
      stop_lat_d = 1'b0;
      error_d    = 1'b0;
      idx_d      = '0;
    end else begin
      if (busy_q && stop) stop_lat_d = 1'b1;
      if (state_q == ST_CHECK) idx_d = idx_q + N_W'(1);
      if ((state_q inside {ST_MEAS_HI, ST_MEAS_LO}) && (state_d == ST_DONE))
        error_d = 1'b1;
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    sw_pc_d     = sw_pc_q;
    azmux_d     = azmux_q;
    adc_is_hi_d = adc_is_hi_q;
    adc_start_d = 1'b0;
    case (state_d)
      ST_IDLE, ST_DONE: begin
        sw_pc_d = SW_PC_BOOT;
        azmux_d = 4'b0000;
      end
      ST_PROTECT: begin
        sw_pc_d = SW_PC_BOOT;
        azmux_d = lo_val_d;
      end
      ST_SETTLE_HI: begin
        sw_pc_d = SW_PC_BOOT;
        azmux_d = hi_val_d;
      end
      ST_MEAS_HI: begin
        sw_pc_d = SW_PC_SIGNAL;
        azmux_d = hi_val_d;
        if (entering) begin
          adc_start_d = 1'b1;
          adc_is_hi_d = 1'b1;
        end
      end
      ST_REPROTECT: sw_pc_d = SW_PC_BOOT;
      ST_MEAS_LO: begin
        sw_pc_d = SW_PC_BOOT;
        azmux_d = lo_val_d;
        if (entering) begin
          adc_start_d = 1'b1;
          adc_is_hi_d = 1'b0;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    led0_d = (sw_pc_d == SW_PC_SIGNAL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_az_q   <= 1'b0;
      hi_val_q    <= 4'b0000;
      lo_val_q    <= 4'b0000;
      pc_clks_q   <= '0;
      count_q     <= '0;
      to_clks_q   <= '0;
      stop_lat_q  <= 1'b0;
      error_q     <= 1'b0;
      idx_q       <= '0;
      sw_pc_q     <= SW_PC_BOOT;
      azmux_q     <= 4'b0000;
      adc_start_q <= 1'b0;
      adc_is_hi_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      led0_q      <= (SW_PC_BOOT == SW_PC_SIGNAL);
      adc_done_q  <= 1'b0;
    end else begin
      mode_az_q   <= mode_az_d;
      hi_val_q    <= hi_val_d;
      lo_val_q    <= lo_val_d;
      pc_clks_q   <= pc_clks_d;
      count_q     <= count_d;
      to_clks_q   <= to_clks_d;
      stop_lat_q  <= stop_lat_d;
      error_q     <= error_d;
      idx_q       <= idx_d;
      sw_pc_q     <= sw_pc_d;
      azmux_q     <= azmux_d;
      adc_start_q <= adc_start_d;
      adc_is_hi_q <= adc_is_hi_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      led0_q      <= led0_d;
      adc_done_q  <= adc_done;
    end
  end

  assign adc_start  = adc_start_q;
  assign adc_is_hi  = adc_is_hi_q;
  assign sw_pc_ctl  = sw_pc_q;
  assign azmux      = azmux_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign sample_idx = idx_q;
  assign led0       = led0_q;
  assign monitor    = {2'b00, adc_is_hi_q, adc_done_q, adc_start_q, state_q};

endmodule

// File: tb/tb_az_sequencer.sv
// Directed and randomized runs of az_sequencer against a cycle-timeline model
// of the hi/lo conversion sequence built from settle length and ADC latency.
module tb_az_sequencer;

  localparam int PC_W = 24;
  localparam int N_W  = 16;

  logic            clk = 1'b0;
  logic            reset, start, stop, mode_az, adc_done;
  logic [3:0]      azmux_hi_val, azmux_lo_val;
  logic [PC_W-1:0] precharge_clks;
  logic [N_W-1:0]  sample_count;
  logic [31:0]     adc_timeout_clks;
  logic            adc_start, adc_is_hi, sw_pc_ctl, busy, done, error, led0;
  logic [3:0]      azmux;
  logic [N_W-1:0]  sample_idx;
  logic [7:0]      monitor;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // ADC responder control
  int resp_delay = -1;
  bit resp_echo = 1'b0;
  int resp_cnt = 0;
  bit resp_pending = 1'b0;

  // Observations gathered each negedge
  logic [31:0] act_start_q[$];
  logic [31:0] act_hi_q[$];
  logic [31:0] act_pc_q[$];
  logic [31:0] act_mux_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_hi_q[$];
  int done_cnt, done_cyc, err_cyc, sig_cycles, hi_cycles, led_bad;
  logic [3:0] done_mux;

  az_sequencer #(.PC_W(PC_W), .N_W(N_W), .SW_PC_SIGNAL(1'b1), .SW_PC_BOOT(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode_az(mode_az),
    .azmux_hi_val(azmux_hi_val), .azmux_lo_val(azmux_lo_val),
    .precharge_clks(precharge_clks), .sample_count(sample_count),
    .adc_timeout_clks(adc_timeout_clks), .adc_done(adc_done),
    .adc_start(adc_start), .adc_is_hi(adc_is_hi), .sw_pc_ctl(sw_pc_ctl),
    .azmux(azmux), .busy(busy), .done(done), .error(error),
    .sample_idx(sample_idx), .led0(led0), .monitor(monitor)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ADC responder ----------------
  initial begin
    adc_done = 1'b0;
    forever begin
      @(negedge clk);
      adc_done = 1'b0;
      if (adc_start && resp_echo) adc_done = 1'b1;
      if (adc_start && resp_delay >= 0) begin
        resp_pending = 1'b1;
        resp_cnt = resp_delay;
      end
      if (resp_pending) begin
        if (resp_cnt == 0) begin
          adc_done = 1'b1;
          resp_pending = 1'b0;
        end else begin
          resp_cnt--;
        end
      end
    end
  end

  // ---------------- observer ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (adc_start) begin
        act_start_q.push_back(cyc);
        act_hi_q.push_back({31'd0, adc_is_hi});
        act_pc_q.push_back({31'd0, sw_pc_ctl});
        act_mux_q.push_back({28'd0, azmux});
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_mux = azmux;
      end
      if (sw_pc_ctl == 1'b1) sig_cycles++;
      if (busy && azmux == azmux_hi_val) hi_cycles++;
      if (error && busy && err_cyc < 0) err_cyc = cyc;
      if (led0 !== sw_pc_ctl) led_bad++;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    act_start_q.delete(); act_hi_q.delete(); act_pc_q.delete(); act_mux_q.delete();
    exp_q.delete(); exp_hi_q.delete();
    done_cnt = 0; done_cyc = -1; err_cyc = -1; sig_cycles = 0; hi_cycles = 0;
    done_mux = 4'hf;
  endtask

  task automatic pick_codes();
    int h;
    h = $urandom_range(0, 7);
    azmux_hi_val = 4'(8 | h);
    azmux_lo_val = 4'(8 | ((h + 1 + $urandom_range(0, 6)) % 8));
  endtask

  task automatic wait_done(input int budget);
    while (done_cnt == 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    chk("done_seen", {31'd0, done_cnt != 0}, 32'd1);
  endtask

  // One complete run; stop_j > 0 makes it continuous and stops during the
  // stop_j-th hi conversion, which then behaves like a count of stop_j.
  task automatic do_run(input bit az, input int pc, input int n, input int d,
                        input bit echo, input int stop_j);
    int s, settle, t, dc, n_eff, budget, first_start, done_exp;
    @(negedge clk);
    clear_obs();
    pick_codes();
    mode_az = az;
    precharge_clks = PC_W'(pc);
    n_eff = (stop_j > 0) ? stop_j : n;
    sample_count = (stop_j > 0) ? '0 : N_W'(n);
    adc_timeout_clks = ($urandom_range(0, 1) != 0) ? 32'd0 : 32'd200;
    resp_delay = d;
    resp_echo = echo;
    start = 1'b1;
    stop = ($urandom_range(0, 1) != 0);
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("error_cleared", {31'd0, error}, 32'd0);
    if (stop_j > 0) begin
      budget = 3000;
      while (act_start_q.size() < 2 * stop_j - 1 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end
    wait_done(3000);
    repeat (3) @(negedge clk);

    // reference timeline
    settle = (pc == 0) ? 1 : pc;
    t = s + 1 + 2 * settle;
    first_start = t;
    done_exp = 0;
    for (int i = 0; i < n_eff; i++) begin
      exp_q.push_back(t); exp_hi_q.push_back(1);
      dc = t + d;
      if (az) begin
        t = dc + settle + 1;
        exp_q.push_back(t); exp_hi_q.push_back(0);
        dc = t + d;
      end
      if (i == n_eff - 1) done_exp = dc + 2;
      else t = dc + 2 + (az ? settle : 0);
    end

    chk("n_starts", act_start_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_start_q.size()) begin
        chk("start_cyc", act_start_q[i], exp_q[i]);
        chk("start_is_hi", act_hi_q[i], exp_hi_q[i]);
        chk("start_sw_pc", act_pc_q[i], exp_hi_q[i]);
        chk("start_azmux", act_mux_q[i],
            {28'd0, (exp_hi_q[i] != 0) ? azmux_hi_val : azmux_lo_val});
      end
    end
    chk("done_count", done_cnt, 1);
    chk("done_cyc", done_cyc, done_exp);
    chk("done_azmux", {28'd0, done_mux}, 32'd0);
    chk("sample_idx", {16'd0, sample_idx}, n_eff);
    chk("error_end", {31'd0, error}, 32'd0);
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("state_idle", {29'd0, monitor[2:0]}, 32'd0);
    chk("sig_cycles", sig_cycles, az ? n_eff * (d + 1) : done_exp - first_start);
    chk("hi_cycles", hi_cycles,
        az ? n_eff * (2 * settle + d + 1) : settle + done_exp - first_start);
    chk("led0_tracks", led_bad, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s, e, settle, k;
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode_az = 1'b0;
    azmux_hi_val = 4'b1000; azmux_lo_val = 4'b1001;
    precharge_clks = '0; sample_count = '0; adc_timeout_clks = '0;
    led_bad = 0;
    clear_obs();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_state", {29'd0, monitor[2:0]}, 32'd0);
    chk("rst_sw_pc", {31'd0, sw_pc_ctl}, 32'd0);
    chk("rst_azmux", {28'd0, azmux}, 32'd0);
    chk("rst_adc_start", {31'd0, adc_start}, 32'd0);
    chk("rst_adc_is_hi", {31'd0, adc_is_hi}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_sample_idx", {16'd0, sample_idx}, 32'd0);
    chk("rst_led0", {31'd0, led0}, 32'd0);

    // AZ run, 10-clock settles, ADC latency 5
    do_run(1'b1, 10, 2, 5, 1'b0, 0);
    // no-AZ, three hi conversions
    do_run(1'b0, $urandom_range(1, 8), 3, $urandom_range(1, 6), 1'b0, 0);
    // continuous AZ ended by stop during a hi conversion
    do_run(1'b1, $urandom_range(1, 5), 0, $urandom_range(2, 5), 1'b0, $urandom_range(1, 3));

    // ADC never answers: timeout after 20 clocks
    @(negedge clk);
    clear_obs();
    pick_codes();
    mode_az = 1'($urandom_range(0, 1));
    settle = $urandom_range(1, 4);
    precharge_clks = PC_W'(settle);
    sample_count = N_W'(1);
    adc_timeout_clks = 32'd20;
    resp_delay = -1;
    resp_echo = 1'b0;
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_done(500);
    repeat (2) @(negedge clk);
    e = s + 1 + 2 * settle;
    chk("to_n_starts", act_start_q.size(), 1);
    if (act_start_q.size() > 0) chk("to_start_cyc", act_start_q[0], e);
    chk("to_error_cyc", err_cyc, e + 20);
    chk("to_done_cyc", done_cyc, e + 20);
    chk("to_done_azmux", {28'd0, done_mux}, 32'd0);
    chk("to_error_sticky", {31'd0, error}, 32'd1);
    chk("to_sample_idx", {16'd0, sample_idx}, 32'd0);
    // following run must clear the flag
    do_run(1'b1, 2, 1, 3, 1'b0, 0);

    // reset during SETTLE_HI, with a start ignored while busy
    @(negedge clk);
    clear_obs();
    pick_codes();
    mode_az = 1'b1;
    precharge_clks = PC_W'(10);
    sample_count = N_W'(2);
    adc_timeout_clks = 32'd0;
    resp_delay = 3;
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (monitor[2:0] != 3'd2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("settle_hi_entry", cyc, s + 1 + 10);
    chk("settle_hi_azmux", {28'd0, azmux}, {28'd0, azmux_hi_val});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rr_state", {29'd0, monitor[2:0]}, 32'd0);
    chk("rr_sw_pc", {31'd0, sw_pc_ctl}, 32'd0);
    chk("rr_azmux", {28'd0, azmux}, 32'd0);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    chk("rr_no_done", done_cnt, 0);
    chk("rr_no_start", act_start_q.size(), 0);

    // zero precharge, ADC echoes a done in the adc_start cycle
    do_run(1'b1, 0, $urandom_range(1, 2), $urandom_range(2, 4), 1'b1, 0);
    do_run(1'b0, 0, 2, $urandom_range(1, 4), 1'b1, 0);

    // randomized runs
    for (int r = 0; r < 4; r++) begin
      do_run(1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(1, 3),
             $urandom_range(1, 5), 1'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
